// File: rtl/tx_scrambler_if.sv
// Byte-lane bus between the framing/ordered-set mux and the per-lane TX scrambler.
// master = upstream mux (drives bytes and block flags), slave = scrambler (drives scrambled bytes).
// Optional TX_SCRAMBLE_DISABLE_EN adds the link-training "Disable Scrambling" control.
interface tx_scrambler_if;
    logic [2:0]  generation;
    logic [31:0] inData;
    logic [3:0]  inDataK;
    logic [3:0]  inDataValid;
    logic        inOsBlock;
    logic        inSkpBlock;
    logic        inLfsrReset;
`ifdef TX_SCRAMBLE_DISABLE_EN
    logic        inDisableScrambling;
`endif
    logic [31:0] scramblerDataOut;
    logic [3:0]  scramblerDataK;
    logic [3:0]  scramblerDataValid;

    modport master (
`ifdef TX_SCRAMBLE_DISABLE_EN
        output inDisableScrambling,
`endif
        output generation, inData, inDataK, inDataValid,
        output inOsBlock, inSkpBlock, inLfsrReset,
        input  scramblerDataOut, scramblerDataK, scramblerDataValid
    );

    modport slave (
`ifdef TX_SCRAMBLE_DISABLE_EN
        input  inDisableScrambling,
`endif
        input  generation, inData, inDataK, inDataValid,
        input  inOsBlock, inSkpBlock, inLfsrReset,
        output scramblerDataOut, scramblerDataK, scramblerDataValid
    );
endinterface

// File: rtl/tx_scrambler.sv
// Per-lane PCIe TX scrambler, up to 4 bytes/cycle: 16-bit LFSR for Gen1/2, 23-bit per-lane-seeded LFSR for Gen3-5.
// Latency: 1 pclk, registered outputs; byte chain within a cycle is combinational.
// Backpressure: none, a new 4-byte word is accepted every cycle. Optional macro TX_SCRAMBLE_DISABLE_EN.
module tx_scrambler #(
    parameter int          LANE_NUM   = 0,
    parameter logic [15:0] GEN12_SEED = 16'hFFFF
) (
    input  logic          pclk,
    input  logic          reset_n,
    tx_scrambler_if.slave bus
);

    // Gen3+ seeds differ per lane so adjacent lanes do not carry correlated patterns.
    function automatic logic [22:0] lane_seed(input int lane);
        case (lane)
            0:       return 23'h1DBFBC;
            1:       return 23'h0607BB;
            2:       return 23'h1EC760;
            3:       return 23'h18C0DB;
            4:       return 23'h010F12;
            5:       return 23'h19CFC9;
            6:       return 23'h0277CE;
            7:       return 23'h1BB807;
            default: return 23'h1DBFBC;
        endcase
    endfunction

    localparam logic [22:0] GEN3_SEED = lane_seed(LANE_NUM);
    localparam logic [15:0] TAPS16    = 16'h0039;   // x^5+x^4+x^3+1 feedback, Galois form
    localparam logic [22:0] TAPS23    = 23'h210125; // x^21+x^16+x^8+x^5+x^2+1 feedback, Galois form
    localparam logic [7:0]  COM_SYM   = 8'hBC;
    localparam logic [7:0]  SKP_SYM   = 8'h1C;

    // One byte of keystream (LSB first) plus the LFSR state 8 shifts later: {ks, next}.
    function automatic logic [23:0] step16(input logic [15:0] s);
        logic [15:0] t;
        logic [7:0]  ks;
        t  = s;
        ks = '0;
        for (int j = 0; j < 8; j++) begin
            ks[j] = t[15];
            t     = {t[14:0], 1'b0} ^ (t[15] ? TAPS16 : 16'h0000);
        end
        return {ks, t};
    endfunction

    function automatic logic [30:0] step23(input logic [22:0] s);
        logic [22:0] t;
        logic [7:0]  ks;
        t  = s;
        ks = '0;
        for (int j = 0; j < 8; j++) begin
            ks[j] = t[22];
            t     = {t[21:0], 1'b0} ^ (t[22] ? TAPS23 : 23'h000000);
        end
        return {ks, t};
    endfunction

    logic [15:0] lfsr16_q;
    logic [22:0] lfsr23_q;
    logic [2:0]  gen_q;
    logic [31:0] dat_q;
    logic [3:0]  k_q;
    logic [3:0]  vld_q;

    logic        scr_off;
    logic        gen12;
    logic        gen3p;
    logic        gen_chg;
    logic [15:0] nxt16;
    logic [22:0] nxt23;
    logic [31:0] nxt_dat;
    logic [23:0] r16;
    logic [30:0] r23;
    logic [7:0]  byte_in;
    logic [7:0]  ks_byte;

`ifdef TX_SCRAMBLE_DISABLE_EN
    assign scr_off = bus.inDisableScrambling;
`else
    assign scr_off = 1'b0;
`endif

    assign gen12   = (bus.generation == 3'd1) || (bus.generation == 3'd2);
    assign gen3p   = (bus.generation >= 3'd3) && (bus.generation <= 3'd5);
    assign gen_chg = (bus.generation != gen_q);

    // Byte chain 0..3: each byte sees the LFSR state left by the previous byte of the same cycle.
    always_comb begin
        nxt16   = (gen12 && gen_chg) ? GEN12_SEED : lfsr16_q;
        nxt23   = (gen3p && gen_chg) ? GEN3_SEED  : lfsr23_q;
        nxt_dat = '0;
        r16     = '0;
        r23     = '0;
        byte_in = '0;
        ks_byte = '0;
        for (int i = 0; i < 4; i++) begin
            byte_in = bus.inData[8*i +: 8];
            r16     = step16(nxt16);
            r23     = step23(nxt23);
            if (bus.inDataValid[i]) begin
                if (gen12) begin
                    ks_byte = scr_off ? 8'h00 : r16[23:16];
                    if (bus.inDataK[i] && byte_in == COM_SYM) begin
                        nxt_dat[8*i +: 8] = byte_in;
                        nxt16             = GEN12_SEED;
                    end else if (bus.inDataK[i] && byte_in == SKP_SYM) begin
                        nxt_dat[8*i +: 8] = byte_in;
                    end else if (bus.inDataK[i]) begin
                        nxt_dat[8*i +: 8] = byte_in;
                        nxt16             = r16[15:0];
                    end else begin
                        nxt_dat[8*i +: 8] = byte_in ^ ks_byte;
                        nxt16             = r16[15:0];
                    end
                end else if (gen3p) begin
                    ks_byte = scr_off ? 8'h00 : r23[30:23];
                    if (bus.inSkpBlock) begin
                        nxt_dat[8*i +: 8] = byte_in;
                    end else if (bus.inOsBlock) begin
                        nxt_dat[8*i +: 8] = byte_in;
                        nxt23             = r23[22:0];
                    end else begin
                        nxt_dat[8*i +: 8] = byte_in ^ ks_byte;
                        nxt23             = r23[22:0];
                    end
                end
            end
        end
        // EIEOS reload applies after this cycle's bytes have used the running state.
        if (gen3p && bus.inLfsrReset) begin
            nxt23 = GEN3_SEED;
        end
    end

    // Register the chain result; an invalid generation zeroes the outputs while both LFSRs hold.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr16_q <= GEN12_SEED;
            lfsr23_q <= GEN3_SEED;
            gen_q    <= '0;
            dat_q    <= '0;
            k_q      <= '0;
            vld_q    <= '0;
        end else begin
            lfsr16_q <= nxt16;
            lfsr23_q <= nxt23;
            gen_q    <= bus.generation;
            if (gen12 || gen3p) begin
                dat_q <= nxt_dat;
                k_q   <= bus.inDataK;
                vld_q <= bus.inDataValid;
            end else begin
                dat_q <= '0;
                k_q   <= '0;
                vld_q <= '0;
            end
        end
    end

    assign bus.scramblerDataOut   = dat_q;
    assign bus.scramblerDataK     = k_q;
    assign bus.scramblerDataValid = vld_q;

endmodule

// File: tb/tb_tx_scrambler.sv
// Bench for tx_scrambler: lanes 0 and 5 driven with identical stimulus.
// Expected words come from a keystream-position model and are queued per cycle.
// A monitor pops one expectation per clock and compares both lanes.
`timescale 1ns/1ps
module tb_tx_scrambler;

    localparam int KS_LEN = 8192;

    logic pclk    = 1'b0;
    logic reset_n = 1'b0;
    always #5 pclk = ~pclk;

    tx_scrambler_if bus0 ();
    tx_scrambler_if bus5 ();

    tx_scrambler #(.LANE_NUM(0)) dut0 (.pclk(pclk), .reset_n(reset_n), .bus(bus0));
    tx_scrambler #(.LANE_NUM(5)) dut5 (.pclk(pclk), .reset_n(reset_n), .bus(bus5));

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d5;
        logic [3:0]  k;
        logic [3:0]  v;
        logic [63:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Keystreams: byte n is what the scrambler XORs onto the n-th advancing byte after a seed.
    logic [7:0] ks16   [KS_LEN];
    logic [7:0] ks23_0 [KS_LEN];
    logic [7:0] ks23_5 [KS_LEN];

    // Model state: position in each keystream, and last generation seen.
    int         m_pos16 = 0;
    int         m_pos23 = 0;
    logic [2:0] m_gen   = 3'd0;

    task automatic build_ks();
        int unsigned s16, s0, s5;
        s16 = 32'hFFFF;
        s0  = 32'h1DBFBC;
        s5  = 32'h19CFC9;
        for (int n = 0; n < KS_LEN; n++) begin
            for (int j = 0; j < 8; j++) begin
                ks16[n][j]   = s16[15];
                ks23_0[n][j] = s0[22];
                ks23_5[n][j] = s5[22];
                s16 = ((s16 << 1) & 32'hFFFF)   ^ (s16[15] ? 32'h0039   : 32'h0);
                s0  = ((s0  << 1) & 32'h7FFFFF) ^ (s0[22]  ? 32'h210125 : 32'h0);
                s5  = ((s5  << 1) & 32'h7FFFFF) ^ (s5[22]  ? 32'h210125 : 32'h0);
            end
        end
    endtask

    task automatic drive(input logic [2:0] gen, input logic [31:0] d, input logic [3:0] k,
                         input logic [3:0] v, input bit os, input bit skp, input bit lrst);
        bus0.generation = gen; bus5.generation = gen;
        bus0.inData = d;       bus5.inData = d;
        bus0.inDataK = k;      bus5.inDataK = k;
        bus0.inDataValid = v;  bus5.inDataValid = v;
        bus0.inOsBlock = os;   bus5.inOsBlock = os;
        bus0.inSkpBlock = skp; bus5.inSkpBlock = skp;
        bus0.inLfsrReset = lrst; bus5.inLfsrReset = lrst;
`ifdef TX_SCRAMBLE_DISABLE_EN
        bus0.inDisableScrambling = 1'b0;
        bus5.inDisableScrambling = 1'b0;
`endif
    endtask

    // One input cycle: drive, advance the model, queue the expected output word.
    // lit=1 replaces the model's data word with a hand-derived literal for both lanes.
    task automatic cyc(input logic [63:0] tag, input logic [2:0] gen, input logic [31:0] d,
                       input logic [3:0] k, input logic [3:0] v, input bit os, input bit skp,
                       input bit lrst, input bit lit, input logic [31:0] lit_d);
        exp_t       e;
        logic [7:0] b, o0, o5;
        bit         g12, g3;
        @(negedge pclk);
        reset_n = 1'b1;
        drive(gen, d, k, v, os, skp, lrst);
        g12 = (gen == 3'd1) || (gen == 3'd2);
        g3  = (gen >= 3'd3) && (gen <= 3'd5);
        e.d0 = '0; e.d5 = '0; e.k = '0; e.v = '0; e.tag = tag;
        if (g12 && gen != m_gen) m_pos16 = 0;
        if (g3  && gen != m_gen) m_pos23 = 0;
        if (g12 || g3) begin
            e.k = k;
            e.v = v;
        end
        for (int i = 0; i < 4; i++) begin
            if ((g12 || g3) && v[i]) begin
                b  = d[8*i +: 8];
                o0 = b;
                o5 = b;
                if (g12) begin
                    if (k[i] && b == 8'hBC) begin
                        m_pos16 = 0;
                    end else if (!(k[i] && b == 8'h1C)) begin
                        if (!k[i]) begin
                            o0 = b ^ ks16[m_pos16];
                            o5 = o0;
                        end
                        m_pos16++;
                    end
                end else if (!skp) begin
                    if (!os) begin
                        o0 = b ^ ks23_0[m_pos23];
                        o5 = b ^ ks23_5[m_pos23];
                    end
                    m_pos23++;
                end
                e.d0[8*i +: 8] = o0;
                e.d5[8*i +: 8] = o5;
            end
        end
        if (g3 && lrst) m_pos23 = 0;
        m_gen = gen;
        if (lit) begin
            e.d0 = lit_d;
            e.d5 = lit_d;
        end
        exp_q.push_back(e);
    endtask

    // Hold reset for n cycles; outputs must clear immediately and stay zero.
    task automatic do_reset(input int n);
        exp_t e;
        e.d0 = '0; e.d5 = '0; e.k = '0; e.v = '0; e.tag = "RST";
        for (int c = 0; c < n; c++) begin
            @(negedge pclk);
            reset_n = 1'b0;
            drive(3'd2, $urandom, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(e);
            if (c == 0) begin
                #1;
                n_tests++;
                if (bus0.scramblerDataOut !== 32'h0 || bus0.scramblerDataValid !== 4'h0 ||
                    bus5.scramblerDataOut !== 32'h0 || bus5.scramblerDataK !== 4'h0) begin
                    n_fail++;
                    $display("FAIL async_reset_clear: lane0 d=%h v=%h lane5 d=%h k=%h, required all 0",
                             bus0.scramblerDataOut, bus0.scramblerDataValid,
                             bus5.scramblerDataOut, bus5.scramblerDataK);
                end
            end
        end
        m_pos16 = 0;
        m_pos23 = 0;
        m_gen   = 3'd0;
    endtask

    // Monitor: one registered output word per clock, checked one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus0.scramblerDataOut !== e.d0 || bus5.scramblerDataOut !== e.d5 ||
                    bus0.scramblerDataK !== e.k || bus5.scramblerDataK !== e.k ||
                    bus0.scramblerDataValid !== e.v || bus5.scramblerDataValid !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got lane0 d=%h k=%h v=%h lane5 d=%h k=%h v=%h; want d0=%h d5=%h k=%h v=%h",
                             e.tag, bus0.scramblerDataOut, bus0.scramblerDataK, bus0.scramblerDataValid,
                             bus5.scramblerDataOut, bus5.scramblerDataK, bus5.scramblerDataValid,
                             e.d0, e.d5, e.k, e.v);
                end
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: stimulus did not complete, required completion before 400us");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [2:0]  gen;
        logic [31:0] d;
        logic [3:0]  k, v;
        int          r;
        build_ks();
        drive(3'd0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        do_reset(3);

        // Gen1 COM then single D00 bytes: the classic FF 17 C0 14 keystream start.
        cyc("T1_COM", 3'd1, 32'h000000BC, 4'h1, 4'h1, 0, 0, 0, 1, 32'h000000BC);
        cyc("T1_D0",  3'd1, 32'h00000000, 4'h0, 4'h1, 0, 0, 0, 1, 32'h000000FF);
        cyc("T1_D1",  3'd1, 32'h00000000, 4'h0, 4'h1, 0, 0, 0, 1, 32'h00000017);
        cyc("T1_D2",  3'd1, 32'h00000000, 4'h0, 4'h1, 0, 0, 0, 1, 32'h000000C0);
        cyc("T1_D3",  3'd1, 32'h00000000, 4'h0, 4'h1, 0, 0, 0, 1, 32'h00000014);

        // SKP symbols pass through and do not advance the LFSR.
        cyc("T3_COM", 3'd1, 32'h000000BC, 4'h1, 4'h1, 0, 0, 0, 1, 32'h000000BC);
        repeat (3) cyc("T3_SKP", 3'd1, 32'h0000001C, 4'h1, 4'h1, 0, 0, 0, 1, 32'h0000001C);
        cyc("T3_D0",  3'd1, 32'h00000000, 4'h0, 4'h1, 0, 0, 0, 1, 32'h000000FF);

        // Gen2 four bytes per cycle: COM in byte 3 reseeds for the next word.
        cyc("T2_W0", 3'd2, 32'hBC000000, 4'h8, 4'hF, 0, 0, 0, 1, 32'hBCC017FF);
        cyc("T2_W1", 3'd2, 32'h00000000, 4'h0, 4'hF, 0, 0, 0, 1, 32'h14C017FF);
        cyc("T2_INV", 3'd2, 32'hA5A5A5A5, 4'h0, 4'h5, 0, 0, 0, 0, 32'h0);

        // Gen3 zero data: raw keystream per lane, then EIEOS reload restarts it.
        for (int c = 0; c < 64; c++) cyc("T4_G3", 3'd3, 32'h0, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);
        cyc("T4_LRST", 3'd3, 32'h0, 4'h0, 4'hF, 0, 0, 1, 0, 32'h0);
        for (int c = 0; c < 4; c++) cyc("T4_RST0", 3'd3, 32'h0, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);

        // SKP block holds the sequence; OS block skips 4 keystream bytes.
        cyc("T5_D",   3'd4, $urandom, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);
        cyc("T5_SKP", 3'd4, 32'hAAAAAAAA, 4'h0, 4'hF, 1, 1, 0, 0, 32'h0);
        cyc("T5_D",   3'd4, $urandom, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);
        cyc("T5_OS",  3'd4, 32'h1E2D3C4B, 4'h0, 4'hF, 1, 0, 0, 0, 32'h0);
        cyc("T5_D",   3'd4, $urandom, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);

        // Reset mid-stream in Gen2, then the 2->3 switch and invalid generations.
        cyc("T6_COM", 3'd2, 32'h000000BC, 4'h1, 4'h1, 0, 0, 0, 0, 32'h0);
        cyc("T6_D",   3'd2, $urandom, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);
        do_reset(2);
        cyc("T6_COM", 3'd2, 32'h000000BC, 4'h1, 4'h1, 0, 0, 0, 1, 32'h000000BC);
        cyc("T6_D00", 3'd2, 32'h00000000, 4'h0, 4'h1, 0, 0, 0, 1, 32'h000000FF);
        cyc("T6_G3",  3'd3, 32'h0, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);
        cyc("T6_G3",  3'd3, 32'h0, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);
        cyc("T6_G7",  3'd7, 32'hDEADBEEF, 4'hF, 4'hF, 0, 0, 0, 1, 32'h0);
        cyc("T6_G0",  3'd0, 32'h12345678, 4'h3, 4'hF, 0, 0, 0, 1, 32'h0);
        cyc("T6_G3",  3'd3, 32'h0, 4'h0, 4'hF, 0, 0, 0, 0, 32'h0);

        // Randomized traffic across generations, K symbols and block flags.
        gen = 3'd1;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 19) == 0) gen = 3'($urandom_range(0, 7));
            d = $urandom;
            k = 4'h0;
            v = 4'($urandom_range(0, 15));
            if (gen <= 3'd2) begin
                for (int i = 0; i < 4; i++) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) begin
                        d[8*i +: 8] = 8'hBC; k[i] = 1'b1;
                    end else if (r == 1) begin
                        d[8*i +: 8] = 8'h1C; k[i] = 1'b1;
                    end else if (r == 2) begin
                        k[i] = 1'b1;
                    end
                end
            end else begin
                k = 4'($urandom_range(0, 15));
            end
            cyc("RND", gen, d, k, v, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0, 0, 32'h0);
        end

        @(negedge pclk);
        @(negedge pclk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
